tone_synth: RTL and testbench
=============================

# tone_synth

Parametrised multi-channel tone synthesiser that succeeds the single-tone square-wave generator in the audio codec datapath. Each channel has its own phase accumulator, frequency step and enable. A shared waveform mode selects square, sawtooth, triangle or silence, and a shared amplitude scales every channel. Once per sample period the block emits one frame of NUM_CH signed samples, channel 0 first, on an Avalon-ST source with ready/valid backpressure. The source feeds the audio FIFO ahead of the codec DAC serialiser.

## Interface
- DATA_W, 16: sample width, signed two's complement
- PHASE_W, 24: phase accumulator width; must be ≥ DATA_W
- NUM_CH, 2: channel count (2 = left/right)
- CLK_HZ, 50_000_000: clk frequency
- SAMPLE_HZ, 48_000: frame rate; DIV = CLK_HZ/SAMPLE_HZ (truncated); elaboration error if DIV < NUM_CH+3
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- mode  in  2  waveform: 0 square, 1 saw, 2 triangle, 3 silent
- amplitude  in  DATA_W-1  unsigned scale, full scale = 2^(DATA_W-1)-1
- ch_enable  in  NUM_CH  per-channel enable
- ch_step  in  NUM_CH*PHASE_W  per-channel phase increment, channel i at bits [i*PHASE_W +: PHASE_W]
- source_data  out  DATA_W  sample
- source_channel  out  $clog2(NUM_CH) (min 1)  channel of current beat
- source_startofpacket  out  1  high on the channel-0 beat
- source_endofpacket  out  1  high on the channel NUM_CH-1 beat
- source_valid  out  1  beat valid
- source_ready  in  1  sink accepts
- overrun_count  out  16  dropped frames, saturating at 0xFFFF

## Operation
- Tick counter runs 0..DIV-1 and wraps. tick = (count == DIV-1).
- FSM states: IDLE, CALC, EMIT.
- IDLE, on tick: sample mode, amplitude, ch_enable and ch_step into frame registers. Compute each channel's raw wave from its current phase. Then phase_i += step_i mod 2^PHASE_W. Go to CALC.
- CALC, one cycle: out_i = (wave_i * amplitude) >>> (DATA_W-1), signed, flooring. Load the frame buffer. Go to EMIT with beat index 0.
- EMIT: present beat k. When valid && ready, set k++. When the beat at k = NUM_CH-1 is accepted, go to IDLE.
- Raw waves use u = phase[PHASE_W-1 -: DATA_W]:
  - square: u MSB 0 → +(2^(DATA_W-1)-1), else −(2^(DATA_W-1)-1)
  - saw: $signed(u)
  - triangle: v = u MSB ? ~u : u; wave = (v<<1) − 2^(DATA_W-1)
  - silent: 0
- Disabled channel:
  - emits 0 but still occupies its beat
  - phase is cleared to 0 on every tick while disabled, so re-enable starts at phase 0
- Tick while in EMIT (overrun):
  - the in-flight frame continues unchanged
  - the new frame is dropped
  - enabled phases still advance, so pitch is preserved
  - overrun_count increments, saturating
- A tick cannot occur in CALC, guaranteed by the DIV constraint.
- Configuration inputs affect output only at frame boundaries; a mid-frame change never tears a frame.

## Timing
- Reset values:
  - source_valid, source_startofpacket, source_endofpacket = 0
  - source_data, source_channel = 0
  - overrun_count = 0
  - all phases = 0, tick counter = 0, FSM = IDLE
- First tick occurs in cycle DIV-1 after reset deasserts.
- Tick in cycle T: channel-0 beat valid in cycle T+2.
- With ready held high, a frame takes NUM_CH consecutive cycles; source_valid drops the cycle after the last accepted beat.
- Under backpressure, data, channel, sop and eop are held stable while valid && !ready.
- Reset asserted mid-frame: outputs take their reset values on the next edge; the partial frame is discarded.

## Structure
- Package tone_synth_pkg holds:
  - enum wave_mode_t: WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_SILENT
  - function wave_shape(mode, u) returning the signed raw wave
- Sub-module tone_synth_osc, one instance per channel: phase accumulator plus wave_shape, with enable-clear.
- Top level holds the tick counter, FSM, multiply stage, frame buffer, beat mux and overrun counter.

## Test plan
All scenarios use CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10), NUM_CH=2, PHASE_W=24.
- **Square wave:** mode 0, amplitude 0x4000, ch0 step 0x100000, both enabled, ready high → ch0 frames 0..7 = 0x3FFF, frames 8..15 = 0xC000, repeating; frame spacing 10 cycles; first valid at cycle 11 after reset release.
- **Sawtooth:** mode 1, amplitude 0x7FFF, step 0x100000 → frame 0 = 0x0000, frame 1 = 0x0FFF, frame 8 = 0x8001.
- **Channel framing:** ch1 disabled → every ch1 beat is 0 with source_channel=1 and eop=1, every ch0 beat has sop=1; after ch1 is re-enabled, its first sample corresponds to phase 0.
- **Backpressure:** ready held low for 3 cycles mid-frame → data and channel stable throughout, no beat lost, overrun_count stays 0.
- **Overrun:** ready low for 25 cycles → overrun_count = 2; the next emitted frame's phase reflects 3 advances.
- **Reset mid-frame:** reset asserted on the ch0 beat → valid 0 next cycle; the first frame after release is at phase 0.

Source files
------------

// File: rtl/tone_synth_pkg.sv
// tone_synth_pkg: shared types and raw waveform shaping for tone_synth
package tone_synth_pkg;
    typedef enum logic [1:0] {WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_SILENT} wave_mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_EMIT} state_t;

    // u carries a w-bit phase slice (w <= 32); the w-bit signed wave comes back sign-extended
    function automatic logic signed [31:0] wave_shape(input wave_mode_t mode, input logic [31:0] u, input int w);
        logic [31:0] half, mask, v;
        logic        neg;
        half = 32'd1 << (w - 1);
        mask = (half << 1) - 32'd1;
        neg  = (u & half) != 32'd0;
        v    = (neg ? ~u : u) & mask;
        return $signed(mode == WAVE_SQUARE ? (neg ? 32'd1 - half : half - 32'd1) :
                       mode == WAVE_SAW    ? (neg ? (u | ~mask) : (u & mask)) :
                       mode == WAVE_TRI    ? (v << 1) - half : 32'd0);
    endfunction
endpackage

// File: rtl/tone_synth_osc.sv
// tone_synth_osc: per-channel phase accumulator and raw waveform generator
module tone_synth_osc
    import tone_synth_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     enable,
    input  logic [PHASE_W-1:0]       step,
    input  logic [1:0]               mode,
    output logic signed [DATA_W-1:0] wave
);
    logic [PHASE_W-1:0] phase;

    // a disabled channel parks at phase 0 so re-enabling starts cleanly
    always_ff @(posedge clk)
        if (reset) phase <= '0;
        else if (tick) phase <= enable ? phase + step : '0;

    assign wave = DATA_W'(wave_shape(wave_mode_t'(mode), 32'(phase[PHASE_W-1 -: DATA_W]), DATA_W));
endmodule

// File: rtl/tone_synth.sv
// tone_synth: multi-channel tone synthesiser streaming NUM_CH-sample frames on an Avalon-ST source
module tone_synth
    import tone_synth_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int PHASE_W   = 24,
    parameter int NUM_CH    = 2,
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 48_000
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [1:0]                                   mode,
    input  logic [DATA_W-2:0]                            amplitude,
    input  logic [NUM_CH-1:0]                            ch_enable,
    input  logic [NUM_CH*PHASE_W-1:0]                    ch_step,
    output logic [DATA_W-1:0]                            source_data,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] source_channel,
    output logic                                         source_startofpacket,
    output logic                                         source_endofpacket,
    output logic                                         source_valid,
    input  logic                                         source_ready,
    output logic [15:0]                                  overrun_count
);
    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int CNT_W = DIV > 1 ? $clog2(DIV) : 1;
    localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = 2 * DATA_W;

    if (DIV < NUM_CH + 3) begin : g_div_check
        $error("tone_synth: CLK_HZ/SAMPLE_HZ must be at least NUM_CH+3");
    end
    if (PHASE_W < DATA_W) begin : g_phase_check
        $error("tone_synth: PHASE_W must be at least DATA_W");
    end

    state_t                   state, nxt;
    logic [CNT_W-1:0]         count;
    logic [CH_W-1:0]          beat;
    logic                     tick, last;
    logic [DATA_W-2:0]        amp_r;
    logic signed [DATA_W-1:0] wave  [NUM_CH];
    logic signed [DATA_W-1:0] raw_r [NUM_CH];
    logic [DATA_W-1:0]        frame_r [NUM_CH];

    assign tick = count == CNT_W'(DIV - 1);
    assign last = beat == CH_W'(NUM_CH - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_osc
        tone_synth_osc #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) u_osc (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .enable(ch_enable[i]),
            .step  (ch_step[i*PHASE_W +: PHASE_W]),
            .mode  (mode),
            .wave  (wave[i])
        );
    end

    always_ff @(posedge clk)
        if (reset) count <= '0;
        else count <= tick ? '0 : count + 1'b1;

    always_ff @(posedge clk)
        if (reset) state <= ST_IDLE;
        else state <= nxt;

    always_comb
        nxt = state == ST_IDLE ? (tick ? ST_CALC : ST_IDLE) :
              state == ST_CALC ? ST_EMIT :
              (source_ready && last) ? ST_IDLE : ST_EMIT;

    // frame capture only from IDLE, so an overrun tick never disturbs the frame in flight
    always_ff @(posedge clk)
        if (reset) begin
            amp_r <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                raw_r[c]   <= '0;
                frame_r[c] <= '0;
            end
        end else begin
            if (state == ST_IDLE && tick) begin
                amp_r <= amplitude;
                for (int c = 0; c < NUM_CH; c++) raw_r[c] <= ch_enable[c] ? wave[c] : '0;
            end
            if (state == ST_CALC)
                for (int c = 0; c < NUM_CH; c++)
                    frame_r[c] <= DATA_W'((PROD_W'(raw_r[c]) * PROD_W'($signed({1'b0, amp_r}))) >>> (DATA_W - 1));
        end

    always_ff @(posedge clk)
        if (reset || state != ST_EMIT) beat <= '0;
        else if (source_ready) beat <= last ? '0 : beat + 1'b1;

    always_ff @(posedge clk)
        if (reset) overrun_count <= '0;
        else if (tick && state == ST_EMIT && overrun_count != 16'hFFFF) overrun_count <= overrun_count + 16'd1;

    always_comb begin
        source_valid         = state == ST_EMIT;
        source_channel       = source_valid ? beat : '0;
        source_data          = source_valid ? frame_r[beat] : '0;
        source_startofpacket = source_valid && beat == '0;
        source_endofpacket   = source_valid && last;
    end
endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed and randomized checks of tone_synth against a frame-level reference model
module tb_tone_synth;
    localparam int DW = 16, PW = 24, NC = 2, DIV = 10;

    logic           clk = 1'b0, reset = 1'b1, source_ready = 1'b1;
    logic [1:0]     mode = 2'd0;
    logic [DW-2:0]  amplitude = '0;
    logic [NC-1:0]  ch_enable = '0;
    logic [NC*PW-1:0] ch_step = '0;
    logic [DW-1:0]  source_data;
    logic [0:0]     source_channel;
    logic           source_startofpacket, source_endofpacket, source_valid;
    logic [15:0]    overrun_count;

    typedef struct {int data; int ch; int t;} beat_t;
    beat_t q[$];
    int total = 0, bad = 0, cyc = 0, ovr_m = 0;
    int ph[NC];
    logic pv = 1'b0, pr = 1'b0, prst = 1'b0, psop = 1'b0, peop = 1'b0;
    logic [DW-1:0] pdata = '0;
    logic [0:0] pch = '0;

    tone_synth #(.DATA_W(DW), .PHASE_W(PW), .NUM_CH(NC), .CLK_HZ(1000), .SAMPLE_HZ(100)) dut (
        .clk(clk), .reset(reset), .mode(mode), .amplitude(amplitude), .ch_enable(ch_enable),
        .ch_step(ch_step), .source_data(source_data), .source_channel(source_channel),
        .source_startofpacket(source_startofpacket), .source_endofpacket(source_endofpacket),
        .source_valid(source_valid), .source_ready(source_ready), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected scaled sample from the waveform definitions, with floor division
    function automatic int sample(input int m, input int p, input int amp);
        int u, w, prod, qt;
        u = p / 256;
        w = m == 0 ? (u >= 32768 ? -32767 : 32767) :
            m == 1 ? (u >= 32768 ? u - 65536 : u) :
            m == 2 ? 2 * (u >= 32768 ? 65535 - u : u) - 32768 : 0;
        prod = w * amp;
        qt = prod / 32768;
        if (prod < 0 && qt * 32768 != prod) qt--;
        return qt & 32'h0000FFFF;
    endfunction

    task automatic model_tick();
        if (q.size() > 0) ovr_m = ovr_m == 65535 ? ovr_m : ovr_m + 1;
        else
            for (int c = 0; c < NC; c++)
                q.push_back(beat_t'{ch_enable[c] ? sample(int'(mode), ph[c], int'(amplitude)) : 0, c, cyc});
        for (int c = 0; c < NC; c++)
            ph[c] = ch_enable[c] ? (ph[c] + int'(ch_step[c*PW +: PW])) % (1 << PW) : 0;
    endtask

    task automatic eval();
        beat_t b;
        chk("overrun_count", 32'(overrun_count), ovr_m);
        chk("valid", 32'(source_valid), 32'(q.size() > 0 && cyc >= q[0].t + 2));
        if (pv && !pr && !prst) begin
            chk("hold_data", 32'(source_data), 32'(pdata));
            chk("hold_channel", 32'(source_channel), 32'(pch));
            chk("hold_sop", 32'(source_startofpacket), 32'(psop));
            chk("hold_eop", 32'(source_endofpacket), 32'(peop));
        end
        if (prst && reset) begin
            chk("rst_data", 32'(source_data), 0);
            chk("rst_channel", 32'(source_channel), 0);
            chk("rst_sop", 32'(source_startofpacket), 0);
            chk("rst_eop", 32'(source_endofpacket), 0);
        end
        pv = source_valid; pr = source_ready; prst = reset;
        pdata = source_data; pch = source_channel; psop = source_startofpacket; peop = source_endofpacket;
        if (reset) begin
            q.delete();
            ovr_m = 0;
            ph = '{default: 0};
            return;
        end
        if (cyc % DIV == DIV - 1) model_tick();
        if (source_valid && source_ready && q.size() > 0) begin
            b = q.pop_front();
            chk("data", 32'(source_data), b.data);
            chk("channel", 32'(source_channel), b.ch);
            chk("sop", 32'(source_startofpacket), 32'(b.ch == 0));
            chk("eop", 32'(source_endofpacket), 32'(b.ch == NC - 1));
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            eval();
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic restart();
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_sop();
        int n = 0;
        while (!(source_valid && source_startofpacket) && n < 40) begin
            run(1);
            n++;
        end
        chk("wait_sop", 32'(source_valid && source_startofpacket), 1);
    endtask

    initial begin
        @(negedge clk);
        restart();
        mode = 2'd0; amplitude = 15'h4000; ch_enable = 2'b11; source_ready = 1'b1;
        ch_step = {24'($urandom), 24'h100000};
        run(11);
        chk("first_valid_c11", 32'(source_valid), 1);
        chk("square_f0", 32'(source_data), 32'h3FFF);
        run(80);
        chk("square_f8", 32'(source_data), 32'hC000);
        run(80);

        mode = 2'd1; amplitude = 15'h7FFF;
        restart();
        run(21);
        chk("saw_f1", 32'(source_data), 32'h0FFF);
        run(70);
        chk("saw_f8", 32'(source_data), 32'h8001);
        run(20);

        ch_enable = 2'b01; mode = 2'($urandom_range(0, 2)); amplitude = 15'($urandom);
        run(60);
        ch_enable = 2'b11;
        run(60);

        repeat (6) begin
            mode = 2'($urandom); amplitude = 15'($urandom); ch_enable = 2'($urandom);
            ch_step = {24'($urandom), 24'($urandom)};
            repeat (80) begin
                source_ready = $urandom_range(0, 3) != 0;
                run(1);
            end
        end

        mode = 2'd1; amplitude = 15'h7FFF; ch_enable = 2'b11; ch_step = {24'h030000, 24'h100000};
        source_ready = 1'b1;
        restart();
        wait_sop();
        run(1);
        source_ready = 1'b0;
        run(3);
        source_ready = 1'b1;
        run(20);
        chk("bp_overrun", 32'(overrun_count), 0);

        restart();
        source_ready = 1'b0;
        wait_sop();
        run(25);
        chk("overrun_2", 32'(overrun_count), 2);
        source_ready = 1'b1;
        run(2);
        wait_sop();
        chk("overrun_phase", 32'(source_data), 32'h2FFF);
        run(10);

        wait_sop();
        reset = 1'b1;
        run(1);
        chk("rst_mid_valid", 32'(source_valid), 0);
        run(1);
        reset = 1'b0;
        cyc = 0;
        run(11);
        chk("rst_first_phase0", 32'(source_data), 0);
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
